// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code counter.
// Contents:
//   step_op_e - decoded per-edge operation of the counter
//   max_val   - all-ones value for a given width (terminal count)
//   bin2gray  - reflected binary-to-Gray conversion
//   gray2bin  - Gray-to-binary conversion, used by checkers
// Functions work on MaxWidth-bit vectors; callers zero-extend their operands
// and truncate the results, which keeps the helpers width-agnostic.
package gray_pkg;

    localparam int unsigned MaxWidth = 64;

    typedef enum logic [1:0] {
        OpHold,
        OpLoad,
        OpUp,
        OpDown
    } step_op_e;

    function automatic logic [MaxWidth-1:0] max_val(input int unsigned width);
        logic [MaxWidth-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < MaxWidth; i++) begin
            if (i < width) v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [MaxWidth-1:0] bin2gray(input logic [MaxWidth-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above its position.
    function automatic logic [MaxWidth-1:0] gray2bin(input logic [MaxWidth-1:0] g);
        logic [MaxWidth-1:0] b;
        for (int unsigned i = 0; i < MaxWidth; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_encode_n.sv
// Combinational binary-to-reflected-Gray converter of parametric width.
// Ports:
//   bin_i  [WIDTH-1:0] binary input
//   gray_o [WIDTH-1:0] Gray code of bin_i
// WIDTH must lie in 1..MaxWidth.
module gray_encode_n
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin_i,
    output logic [WIDTH-1:0] gray_o
);

    assign gray_o = WIDTH'(bin2gray(MaxWidth'(bin_i)));

endmodule

// File: rtl/gray_code_counter.sv
// Registered up/down counter presenting its state in binary and Gray code.
// Ports:
//   clk_i       rising-edge clock
//   rst_ni      synchronous active-low reset
//   en_i        count enable, one step per clock
//   up_dn_i     direction: 1 = increment, 0 = decrement
//   load_i      synchronous load strobe (overrides en_i)
//   load_val_i  binary value to load
//   bin_out_o   registered binary count
//   gray_out_o  registered Gray code of bin_out_o
//   wrap_o      one-cycle pulse after a wrap-around step
//   at_limit_o  count sits at the end value for the sampled direction
// WRAP_MODE = 1 wraps modulo 2^WIDTH; WRAP_MODE = 0 saturates and holds.
module gray_code_counter
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter bit          WRAP_MODE = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             up_dn_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] bin_out_o,
    output logic [WIDTH-1:0] gray_out_o,
    output logic             wrap_o,
    output logic             at_limit_o
);

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(max_val(WIDTH));

    step_op_e         op;
    logic [WIDTH-1:0] bin_d, bin_q;
    logic [WIDTH-1:0] gray_d, gray_q;
    logic             wrap_d, wrap_q;
    logic             at_limit_d, at_limit_q;

    always_comb begin
        op = OpHold;
        if (load_i) begin
            op = OpLoad;
        end else if (en_i) begin
            op = up_dn_i ? OpUp : OpDown;
        end
    end

    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        unique case (op)
            OpLoad: bin_d = load_val_i;
            OpUp: begin
                if (bin_q != MaxVal) begin
                    bin_d = bin_q + WIDTH'(1);
                end else if (WRAP_MODE) begin
                    bin_d  = '0;
                    wrap_d = 1'b1;
                end
            end
            OpDown: begin
                if (bin_q != '0) begin
                    bin_d = bin_q - WIDTH'(1);
                end else if (WRAP_MODE) begin
                    bin_d  = MaxVal;
                    wrap_d = 1'b1;
                end
            end
            OpHold: bin_d = bin_q;
            default: bin_d = bin_q;
        endcase
        // Limit is judged against the direction in force at this edge.
        at_limit_d = up_dn_i ? (bin_d == MaxVal) : (bin_d == '0);
    end

    // Gray is derived from the next binary value so both registers load together.
    gray_encode_n #(
        .WIDTH(WIDTH)
    ) u_gray_encode (
        .bin_i (bin_d),
        .gray_o(gray_d)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            bin_q      <= '0;
            gray_q     <= '0;
            wrap_q     <= 1'b0;
            at_limit_q <= ~up_dn_i;
        end else begin
            bin_q      <= bin_d;
            gray_q     <= gray_d;
            wrap_q     <= wrap_d;
            at_limit_q <= at_limit_d;
        end
    end

    assign bin_out_o  = bin_q;
    assign gray_out_o = gray_q;
    assign wrap_o     = wrap_q;
    assign at_limit_o = at_limit_q;

endmodule

// File: tb/tb_gray_code_counter.sv
// Bench for gray_code_counter: three instances (4-bit wrap, 4-bit saturate,
// 8-bit wrap) share one set of control inputs. Expected results are pushed
// to per-instance queues when stimulus is driven and popped after the edge.
module tb_gray_code_counter;
    import gray_pkg::*;

    typedef struct {
        logic [7:0] bin;
        logic [7:0] gray;
        logic       wrap;
        logic       lim;
        int         chg;  // expected Gray bit flips this step, -1 = not checked
    } exp_t;

    typedef struct {
        logic       rst;
        logic       ld;
        logic       en;
        logic       up;
        logic [7:0] val;
        logic [7:0] bin;
        logic [7:0] gray;
        logic       wrap;
        logic       lim;
    } vec_t;

    logic       clk;
    logic       rst_n, en, up_dn, load;
    logic [7:0] load_val;
    logic [3:0] bin_a, gray_a, bin_b, gray_b;
    logic [7:0] bin_c, gray_c;
    logic       wrap_a, lim_a, wrap_b, lim_b, wrap_c, lim_c;

    int n_checks = 0;
    int n_pass   = 0;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    logic [7:0] ma = 8'd0;
    logic [7:0] mb = 8'd0;
    logic [7:0] mc = 8'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    gray_code_counter #(.WIDTH(4), .WRAP_MODE(1'b1)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .up_dn_i(up_dn), .load_i(load),
        .load_val_i(load_val[3:0]), .bin_out_o(bin_a), .gray_out_o(gray_a),
        .wrap_o(wrap_a), .at_limit_o(lim_a)
    );

    gray_code_counter #(.WIDTH(4), .WRAP_MODE(1'b0)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .up_dn_i(up_dn), .load_i(load),
        .load_val_i(load_val[3:0]), .bin_out_o(bin_b), .gray_out_o(gray_b),
        .wrap_o(wrap_b), .at_limit_o(lim_b)
    );

    gray_code_counter #(.WIDTH(8), .WRAP_MODE(1'b1)) u_dut_c (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .up_dn_i(up_dn), .load_i(load),
        .load_val_i(load_val), .bin_out_o(bin_c), .gray_out_o(gray_c),
        .wrap_o(wrap_c), .at_limit_o(lim_c)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Bitwise Gray: g[i] = b[i] ^ b[i+1].
    function automatic logic [7:0] to_gray(input logic [7:0] b);
        logic [7:0] g;
        for (int i = 0; i < 7; i++) g[i] = b[i] ^ b[i+1];
        g[7] = b[7];
        return g;
    endfunction

    function automatic exp_t model(input int unsigned w, input bit wm, input logic [7:0] cur,
                                   input logic rst, input logic ld, input logic en_m,
                                   input logic up, input logic [7:0] val);
        exp_t       e;
        logic [7:0] mask;
        mask   = (w >= 8) ? 8'hFF : 8'((16'd1 << w) - 16'd1);
        e.wrap = 1'b0;
        e.chg  = -1;
        if (!rst) begin
            e.bin = 8'd0;
        end else if (ld) begin
            e.bin = val & mask;
        end else if (en_m) begin
            if (up) begin
                if (cur != mask) e.bin = cur + 8'd1;
                else if (wm) begin e.bin = 8'd0; e.wrap = 1'b1; end
                else e.bin = cur;
            end else begin
                if (cur != 8'd0) e.bin = cur - 8'd1;
                else if (wm) begin e.bin = mask; e.wrap = 1'b1; end
                else e.bin = cur;
            end
            e.chg = (e.bin != cur) ? 1 : 0;
        end else begin
            e.bin = cur;
        end
        e.gray = to_gray(e.bin);
        e.lim  = up ? (e.bin == mask) : (e.bin == 8'd0);
        return e;
    endfunction

    task automatic cmp(input string tag, input exp_t e, input logic [7:0] bin,
                       input logic [7:0] gray, input logic wrap, input logic lim,
                       input logic [7:0] prev_gray);
        check({tag, ".bin"}, bin, e.bin);
        check({tag, ".gray"}, gray, e.gray);
        check({tag, ".wrap"}, 8'(wrap), 8'(e.wrap));
        check({tag, ".at_limit"}, 8'(lim), 8'(e.lim));
        if (e.chg >= 0) check({tag, ".gray_flips"}, 8'($countones(gray ^ prev_gray)), 8'(e.chg));
    endtask

    // Drive one cycle; expected for instance a comes from the vector when use_tab is set.
    task automatic step(input logic rst, input logic ld, input logic e, input logic up,
                        input logic [7:0] val, input bit use_tab, input vec_t v);
        exp_t       ea, eb, ec;
        logic [7:0] pa, pb, pc;
        logic [63:0] g2b;
        rst_n = rst; load = ld; en = e; up_dn = up; load_val = val;
        ea = model(4, 1'b1, ma, rst, ld, e, up, val);
        eb = model(4, 1'b0, mb, rst, ld, e, up, val);
        ec = model(8, 1'b1, mc, rst, ld, e, up, val);
        ma = ea.bin; mb = eb.bin; mc = ec.bin;
        if (use_tab) begin
            ea.bin = v.bin; ea.gray = v.gray; ea.wrap = v.wrap; ea.lim = v.lim;
        end
        qa.push_back(ea); qb.push_back(eb); qc.push_back(ec);
        pa = {4'd0, gray_a}; pb = {4'd0, gray_b}; pc = gray_c;
        @(posedge clk);
        #1;
        cmp("a", qa.pop_front(), {4'd0, bin_a}, {4'd0, gray_a}, wrap_a, lim_a, pa);
        cmp("b", qb.pop_front(), {4'd0, bin_b}, {4'd0, gray_b}, wrap_b, lim_b, pb);
        cmp("c", qc.pop_front(), bin_c, gray_c, wrap_c, lim_c, pc);
        g2b = gray2bin(64'(gray_c));
        check("c.gray2bin", g2b[7:0], bin_c);
    endtask

    vec_t tab[13];
    vec_t nov;

    initial begin
        nov = '{default: 0};
        // rst ld en up val | bin gray wrap lim  (4-bit wrapping instance)
        tab[0]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h0, 8'h0, 8'h0, 1'b0, 1'b0};
        tab[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h0, 8'h0, 8'h0, 1'b0, 1'b0};
        tab[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 8'h0, 8'h0, 1'b0, 1'b1};
        tab[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h9, 8'h9, 8'hD, 1'b0, 1'b0};
        tab[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h0, 8'h0, 8'h0, 1'b0, 1'b0};
        tab[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h0, 8'h0, 8'h0, 1'b0, 1'b1};
        tab[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h0, 8'hF, 8'h8, 1'b1, 1'b0};
        tab[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h0, 8'hE, 8'h9, 1'b0, 1'b0};
        tab[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hA, 8'hA, 8'hF, 1'b0, 1'b0};
        tab[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h0, 8'hB, 8'hE, 1'b0, 1'b0};
        tab[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h0, 8'hB, 8'hE, 1'b0, 1'b0};
        tab[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'hF, 8'hF, 8'h8, 1'b0, 1'b1};
        tab[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h0, 8'h0, 8'h0, 1'b1, 1'b0};

        rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 8'h0;

        for (int i = 0; i < 13; i++) begin
            step(tab[i].rst, tab[i].ld, tab[i].en, tab[i].up, tab[i].val, 1'b1, tab[i]);
        end

        // Full up sweep through the wrap, one Gray bit per step.
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, nov);
        for (int i = 0; i < 17; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, nov);

        // Saturation on the 4-bit saturating instance.
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h0E, 1'b0, nov);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, nov);
            check("sat.bin", {4'd0, bin_b}, 8'hF);
            check("sat.wrap", 8'(wrap_b), 8'h0);
            check("sat.at_limit", 8'(lim_b), 8'h1);
        end
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, nov);
        check("sat.down", {4'd0, bin_b}, 8'hE);

        // 8-bit instance: mid-range carry and top-end wrap.
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h7F, 1'b0, nov);
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, nov);
        check("w8.bin_80", bin_c, 8'h80);
        check("w8.gray_c0", gray_c, 8'hC0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, nov);
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, nov);
        check("w8.wrap_bin", bin_c, 8'h00);
        check("w8.wrap_pulse", 8'(wrap_c), 8'h1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, nov);
        check("w8.wrap_clear", 8'(wrap_c), 8'h0);

        // Randomised stretch, model-checked.
        for (int i = 0; i < 60; i++) begin
            step(($urandom_range(0, 19) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)), 1'b0, nov);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
